// File: rtl/led_pkg.sv
// Shared definitions for the LED display controller: display mode
// encodings and the prescaler divide-ratio helper.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_DIRECT = 2'd1,
        MODE_BAR    = 2'd2,
        MODE_CHASE  = 2'd3
    } mode_t;

    // Number of sys_clk cycles per pattern step.
    function automatic int calc_tick_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_msb_idx.sv
// Combinational leading-one detector: idx is the position of the highest
// set bit of val, nz flags that at least one bit is set (idx is 0 otherwise).
module led_msb_idx #(
    parameter int VAL_W = 32,
    parameter int IDX_W = (VAL_W > 1) ? $clog2(VAL_W) : 1
) (
    input  logic [VAL_W-1:0] val,
    output logic [IDX_W-1:0] idx,
    output logic             nz
);

    // Scan upward so the last (highest) set bit wins.
    always_comb begin
        idx = '0;
        for (int i = 0; i < VAL_W; i++) begin
            if (val[i]) begin
                idx = IDX_W'(i);
            end
        end
        nz = |val;
    end

endmodule

// File: rtl/led_display_ctrl.sv
// LED bank driver for the frequency meter front panel. Latches a measurement
// word and renders it as OFF / DIRECT binary / log2 BAR / CHASE pattern.
// Optional build macro LED_OVF_BLINK_EN: BAR overrange blinks at the tick
// rate instead of showing steady all-ones.
//
// Value handshake: value_valid is a one-cycle strobe with no backpressure;
// every strobe is latched into val_q on that edge, and upd_ack pulses high
// for exactly the following cycle. led/ovf reflect the new value one edge
// after the latch.
module led_display_ctrl
    import led_pkg::*;
#(
    parameter int LED_W   = 16,
    parameter int VAL_W   = 32,
    parameter int CLK_HZ  = 100000000,
    parameter int TICK_HZ = 10
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [VAL_W-1:0] value,
    input  logic             value_valid,
    output logic             upd_ack,
    output logic             ovf,
    output logic [LED_W-1:0] led
);

    localparam int TICK_DIV = calc_tick_div(CLK_HZ, TICK_HZ);
    localparam int CNT_W    = $clog2(TICK_DIV);
    localparam int POS_W    = (LED_W > 1) ? $clog2(LED_W) : 1;
    localparam int IDX_W    = (VAL_W > 1) ? $clog2(VAL_W) : 1;

    logic [VAL_W-1:0] val_q;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    mode_t            mode_q;
    mode_t            mode_in;
    logic [POS_W-1:0] pos;
    logic             chase_entry;

    logic [IDX_W-1:0] msb_idx;
    logic             msb_nz;
    logic [31:0]      idx_ext;
    logic             ovf_c;

    logic [LED_W-1:0]       led_bar;
    logic [LED_W-1:0]       led_bar_out;
    logic [LED_W-1:0]       led_chase;
    logic [LED_W+VAL_W-1:0] val_ext;
    logic [LED_W-1:0]       led_direct;
    logic [LED_W-1:0]       led_c;

    assign mode_in     = mode_t'(mode);
    assign tick        = (cnt == CNT_W'(TICK_DIV - 1));
    assign chase_entry = (mode_in == MODE_CHASE) && (mode_q != MODE_CHASE);

    led_msb_idx #(
        .VAL_W (VAL_W),
        .IDX_W (IDX_W)
    ) u_msb_idx (
        .val (val_q),
        .idx (msb_idx),
        .nz  (msb_nz)
    );

    assign idx_ext = 32'(msb_idx);
    assign ovf_c   = msb_nz && (idx_ext >= 32'(LED_W));

    // Free-running prescaler; only reset clears it.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Value latch and acknowledge pulse.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q   <= '0;
            upd_ack <= 1'b0;
        end else begin
            if (value_valid) begin
                val_q <= value;
            end
            upd_ack <= value_valid;
        end
    end

    // Mode register and chase position; entering CHASE overrides a tick.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_OFF;
            pos    <= '0;
        end else begin
            mode_q <= mode_in;
            if (chase_entry) begin
                pos <= '0;
            end else if (tick) begin
                pos <= (pos == POS_W'(LED_W - 1)) ? '0 : pos + POS_W'(1);
            end
        end
    end

    // Pattern generators for the non-trivial modes.
    always_comb begin
        led_bar   = '0;
        led_chase = '0;
        for (int i = 0; i < LED_W; i++) begin
            led_bar[i]   = msb_nz && (32'(i) <= idx_ext);
            led_chase[i] = (pos == POS_W'(i));
        end
    end

    // Zero-extend before slicing so narrow values leave upper LEDs dark.
    assign val_ext    = {{LED_W{1'b0}}, val_q};
    assign led_direct = val_ext[LED_W-1:0];

`ifdef LED_OVF_BLINK_EN
    logic phase;

    // Blink phase runs only while BAR is showing an overrange value.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= 1'b0;
        end else if ((mode_q == MODE_BAR) && ovf_c) begin
            if (tick) begin
                phase <= ~phase;
            end
        end else begin
            phase <= 1'b0;
        end
    end

    assign led_bar_out = ovf_c ? {LED_W{phase}} : led_bar;
`else
    assign led_bar_out = led_bar;
`endif

    // Output select from registered mode only, so led never sees raw inputs.
    always_comb begin
        led_c = '0;
        case (mode_q)
            MODE_OFF:    led_c = '0;
            MODE_DIRECT: led_c = led_direct;
            MODE_BAR:    led_c = led_bar_out;
            MODE_CHASE:  led_c = led_chase;
            default:     led_c = '0;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
            ovf <= 1'b0;
        end else begin
            led <= led_c;
            ovf <= ovf_c;
        end
    end

endmodule

// File: tb/tb_led_display_ctrl.sv
// Self-checking bench for led_display_ctrl with LED_W=16, VAL_W=32 and a
// 10-cycle tick. Expected LED words are queued when stimulus is driven and
// popped when the DUT output is due.
module tb_led_display_ctrl;

    localparam int LED_W    = 16;
    localparam int VAL_W    = 32;
    localparam int TICK_DIV = 10;

    logic             sys_clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic [VAL_W-1:0] value = '0;
    logic             value_valid = 1'b0;
    logic             upd_ack;
    logic             ovf;
    logic [LED_W-1:0] led;

    int checks = 0;
    int errors = 0;

    logic [LED_W-1:0] exp_q[$];
    logic             exp_ovf_q[$];
    logic [LED_W-1:0] exp_led;
    logic             exp_ovf;

    // Bench copy of the prescaler phase, used only to time ticks.
    int m_cnt;

    led_display_ctrl #(
        .LED_W   (LED_W),
        .VAL_W   (VAL_W),
        .CLK_HZ  (100),
        .TICK_HZ (10)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .value       (value),
        .value_valid (value_valid),
        .upd_ack     (upd_ack),
        .ovf         (ovf),
        .led         (led)
    );

    // ---------------- clock / reset ----------------
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) m_cnt <= 0;
        else        m_cnt <= (m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    // ---------------- reference helpers ----------------
    function automatic logic [LED_W-1:0] bar_model(input logic [VAL_W-1:0] v);
        int k;
        logic [LED_W:0] t;
        k = -1;
        for (int i = 0; i < VAL_W; i++) if (v[i]) k = i;
        if (k < 0) return '0;
        if (k >= LED_W) return '1;
        t = (17'd1 << (k + 1)) - 17'd1;
        return t[LED_W-1:0];
    endfunction

    function automatic logic [LED_W-1:0] led_model(input logic [VAL_W-1:0] v, input logic [1:0] m);
        case (m)
            2'd0: return '0;
            2'd1: return v[LED_W-1:0];
            2'd2: begin
`ifdef LED_OVF_BLINK_EN
                if (|v[VAL_W-1:LED_W]) return '0;
`endif
                return bar_model(v);
            end
            default: return '0;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Strobe one value; returns 1ns after the latching edge.
    task automatic drive_value(input logic [VAL_W-1:0] v, input logic [1:0] m);
        @(posedge sys_clk);
        #1;
        mode        = m;
        value       = v;
        value_valid = 1'b1;
        exp_q.push_back(led_model(v, m));
        exp_ovf_q.push_back(|v[VAL_W-1:LED_W]);
        @(posedge sys_clk);
        #1;
        value_valid = 1'b0;
    endtask

    // Return at the negedge just before the next tick edge.
    task automatic wait_tick();
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            @(negedge sys_clk);
            if (m_cnt == TICK_DIV - 1) return;
        end
        checks++; errors++;
        $display("FAIL tick_wait: got no tick within %0d cycles, expected one", 2 * TICK_DIV);
    endtask

    // Return at a negedge where the prescaler is at the given count.
    task automatic wait_cnt(input int target);
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            @(negedge sys_clk);
            if (m_cnt == target) return;
        end
        checks++; errors++;
        $display("FAIL cnt_wait: got no count %0d within %0d cycles", target, 2 * TICK_DIV);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; mode = 2'd3; value = $urandom; value_valid = 1'b1;
        repeat (3) @(negedge sys_clk);
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL reset_led: got %h expected 0000", led); end
        checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", upd_ack); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        rst_n = 1'b1; value_valid = 1'b0;
        // CHASE held through reset: pos=0 until the 10th edge's tick moves it.
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0002);
        repeat (10) @(posedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL first_tick_e10: got %h expected %h", led, exp_led); end
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL first_tick_e11: got %h expected %h", led, exp_led); end
    endtask

    task automatic test_direct();
        logic [VAL_W-1:0] vals[4];
        vals[0] = 32'h0001A5C3;
        for (int i = 1; i < 4; i++) vals[i] = $urandom;
        for (int i = 0; i < 4; i++) begin
            drive_value(vals[i], 2'd1);
            @(negedge sys_clk);
            checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL direct_ack: got %b expected 1", upd_ack); end
            @(negedge sys_clk);
            exp_led = exp_q.pop_front(); exp_ovf = exp_ovf_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL direct_led: got %h expected %h", led, exp_led); end
            checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL direct_ovf: got %b expected %b", ovf, exp_ovf); end
            checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL direct_ack_drop: got %b expected 0", upd_ack); end
        end
    endtask

    task automatic test_off();
        drive_value(32'h00F0_1234, 2'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front(); exp_ovf = exp_ovf_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL off_led: got %h expected %h", led, exp_led); end
        checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL off_ovf: got %b expected %b", ovf, exp_ovf); end
    endtask

    task automatic test_bar();
        logic [VAL_W-1:0] vals[7];
        vals[0] = 32'h00000100; vals[1] = 32'h00000000; vals[2] = 32'h00000001;
        vals[3] = 32'h00008000;
        for (int i = 4; i < 7; i++) vals[i] = $urandom_range(1, 65535);
        for (int i = 0; i < 7; i++) begin
            drive_value(vals[i], 2'd2);
            @(negedge sys_clk);
            @(negedge sys_clk);
            exp_led = exp_q.pop_front(); exp_ovf = exp_ovf_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL bar_led %h: got %h expected %h", vals[i], led, exp_led); end
            checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL bar_ovf %h: got %b expected %b", vals[i], ovf, exp_ovf); end
        end
    endtask

    task automatic test_back_to_back();
        logic [VAL_W-1:0] v1, v2;
        v1 = $urandom; v2 = $urandom;
        @(posedge sys_clk); #1;
        mode = 2'd1; value = v1; value_valid = 1'b1;
        exp_q.push_back(v1[LED_W-1:0]);
        @(posedge sys_clk); #1;
        value = v2;
        exp_q.push_back(v2[LED_W-1:0]);
        @(negedge sys_clk);
        checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack1: got %b expected 1", upd_ack); end
        @(posedge sys_clk); #1;
        value_valid = 1'b0;
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (upd_ack !== 1'b1) begin errors++; $display("FAIL b2b_ack2: got %b expected 1", upd_ack); end
        checks++; if (led !== exp_led) begin errors++; $display("FAIL b2b_led1: got %h expected %h", led, exp_led); end
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (upd_ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_end: got %b expected 0", upd_ack); end
        checks++; if (led !== exp_led) begin errors++; $display("FAIL b2b_led2: got %h expected %h", led, exp_led); end
    endtask

    task automatic test_chase();
        mode = 2'd0;
        repeat (3) @(negedge sys_clk);
        wait_cnt(2);
        mode = 2'd3;
        exp_q.push_back(16'h0001);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL chase_entry: got %h expected %h", led, exp_led); end
        for (int t = 1; t <= 16; t++) begin
            wait_tick();
            exp_q.push_back(16'h0001 << (t % 16));
            @(negedge sys_clk);
            @(negedge sys_clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL chase_tick%0d: got %h expected %h", t, led, exp_led); end
        end
        // Entry on the same edge as a tick: the load to 0 wins.
        mode = 2'd0;
        repeat (2) @(negedge sys_clk);
        wait_tick();
        mode = 2'd3;
        exp_q.push_back(16'h0001);
        exp_q.push_back(16'h0001);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL chase_coincide: got %h expected %h", led, exp_led); end
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL chase_coincide_hold: got %h expected %h", led, exp_led); end
    endtask

    task automatic test_bar_ovf();
        wait_cnt(2);
        drive_value(32'h80000000, 2'd2);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front(); exp_ovf = exp_ovf_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL ovf_led0: got %h expected %h", led, exp_led); end
        checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", ovf, exp_ovf); end
        for (int t = 0; t < 4; t++) begin
            wait_tick();
`ifdef LED_OVF_BLINK_EN
            exp_q.push_back((t % 2 == 0) ? 16'hFFFF : 16'h0000);
`else
            exp_q.push_back(16'hFFFF);
`endif
            @(negedge sys_clk);
            @(negedge sys_clk);
            exp_led = exp_q.pop_front();
            checks++; if (led !== exp_led) begin errors++; $display("FAIL ovf_tick%0d: got %h expected %h", t, led, exp_led); end
            checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_hold%0d: got %b expected 1", t, ovf); end
        end
    endtask

    task automatic test_reset_mid_chase();
        wait_cnt(2);
        mode = 2'd3;
        repeat (5) wait_tick();
        exp_q.push_back(16'h0020);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL mid_pos5: got %h expected %h", led, exp_led); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (led !== 16'h0000) begin errors++; $display("FAIL async_led: got %h expected 0000", led); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL async_ovf: got %b expected 0", ovf); end
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        exp_q.push_back(16'h0001);
        @(negedge sys_clk);
        @(negedge sys_clk);
        exp_led = exp_q.pop_front();
        checks++; if (led !== exp_led) begin errors++; $display("FAIL post_reset_chase: got %h expected %h", led, exp_led); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_direct();
        test_off();
        test_bar();
        test_back_to_back();
        test_chase();
        test_bar_ovf();
        test_reset_mid_chase();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
